seg7_value_sequencer: RTL

Parametrised successor to the four-value 7-segment display controller. It captures N_VAL unsigned values on a start pulse and shows them one after another, each for a programmable dwell time. Each value is converted to BCD by a sequential double-dabble engine and scanned across N_DIG multiplexed digits. Completion is reported with a level done flag and a busy flag. It sits between the compute datapath (result registers) and the board's anode/cathode pins.

---
 rtl/seg7_value_sequencer.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/seg7_value_sequencer.sv
// Captures N_VAL values on start, converts each to BCD and scans it over
// N_DIG multiplexed digits. Optional macro SEG7_LZB_EN: leading-zero blanking.
`timescale 1ns/1ps
module seg7_value_sequencer #(
    parameter int N_VAL       = 4,
    parameter int VAL_W       = 8,
    parameter int N_DIG       = 4,
    parameter int DWELL_CYC   = 100_000_000,
    parameter int REFRESH_CYC = 262_144
) (
    input  logic                                   clock_100Mhz,
    input  logic                                   reset,
    input  logic                                   start,
    input  logic [N_VAL*VAL_W-1:0]                 vals_i,
    output logic                                   busy_o,
    output logic                                   is_done_o,
    output logic [(N_VAL>1?$clog2(N_VAL):1)-1:0]   idx_o,
    output logic [N_DIG-1:0]                       Anode_Activate,
    output logic [6:0]                             LED_out
);

    localparam int IW     = (N_VAL > 1) ? $clog2(N_VAL) : 1;
    localparam int DW     = $clog2(DWELL_CYC);
    localparam int RW     = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
    localparam int PW     = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam int CW     = $clog2(VAL_W + 1);
    // 2^VAL_W < 10^(VAL_W/3+1), so NB_MIN digits always hold the value
    localparam int NB_MIN = VAL_W / 3 + 1;
    localparam int NB     = (NB_MIN > N_DIG) ? NB_MIN : N_DIG;

`ifdef SEG7_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [N_VAL*VAL_W-1:0] bank_q, bank_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [DW-1:0]          dwell_q, dwell_d;
    logic [RW-1:0]          ref_q, ref_d;
    logic [PW-1:0]          p_q, p_d;
    logic [VAL_W-1:0]       bin_q, bin_d;
    logic [4*NB-1:0]        bcd_q, bcd_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   conv_q, conv_d;
    logic [4*N_DIG-1:0]     dig_q, dig_d;
    logic                   ovf_q, ovf_d;
    logic [N_DIG-1:0]       anode_q, anode_d;
    logic [6:0]             led_q, led_d;

    logic                   accept;
    logic                   dwell_end;
    logic                   last;
    logic                   step;
    logic [VAL_W-1:0]       load_val;
    logic [4*NB-1:0]        bcd_adj;
    logic                   ovf;
    logic                   lz;
    logic [3:0]             sel_dig;
    logic                   sel_blank;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b0000001;
            4'd1:    seg_of = 7'b1001111;
            4'd2:    seg_of = 7'b0010010;
            4'd3:    seg_of = 7'b0000110;
            4'd4:    seg_of = 7'b1001100;
            4'd5:    seg_of = 7'b0100100;
            4'd6:    seg_of = 7'b0100000;
            4'd7:    seg_of = 7'b0001111;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0000100;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    assign accept    = start && (state_q != SHOW);
    assign dwell_end = (state_q == SHOW) &&
                       (dwell_q == DW'(DWELL_CYC - 1));
    assign last      = (idx_q == IW'(N_VAL - 1));
    assign step      = dwell_end && !last;

    always_ff @(posedge clock_100Mhz) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: if (start) state_d = SHOW;
            SHOW:       if (dwell_end && last) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o         = (state_q == SHOW);
        is_done_o      = (state_q == DONE);
        idx_o          = idx_q;
        Anode_Activate = anode_q;
        LED_out        = led_q;
    end

    always_comb begin
        bank_d  = bank_q;
        idx_d   = idx_q;
        dwell_d = dwell_q;
        if (accept) begin
            bank_d  = vals_i;
            idx_d   = '0;
            dwell_d = '0;
        end else if (state_q == SHOW) begin
            if (step) begin
                idx_d   = idx_q + 1'b1;
                dwell_d = '0;
            end else if (!dwell_end) begin
                dwell_d = dwell_q + 1'b1;
            end
        end
    end

    always_comb begin
        load_val = vals_i[VAL_W-1:0];
        if (!accept) begin
            for (int k = 0; k < N_VAL; k++) begin
                if (IW'(k) == idx_d) load_val = bank_q[k*VAL_W +: VAL_W];
            end
        end
    end

    // double dabble: add 3 to every digit >= 5, then shift in the next bit
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ?
                                bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
        end
        ovf = 1'b0;
        for (int i = N_DIG; i < NB; i++) begin
            ovf = ovf || (bcd_q[4*i +: 4] != 4'd0);
        end
        bin_d  = bin_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        conv_d = conv_q;
        dig_d  = dig_q;
        ovf_d  = ovf_q;
        if (accept || step) begin
            bin_d  = load_val;
            bcd_d  = '0;
            cnt_d  = '0;
            conv_d = 1'b1;
        end else if (conv_q) begin
            if (cnt_q == CW'(VAL_W)) begin
                dig_d  = bcd_q[4*N_DIG-1:0];
                ovf_d  = ovf;
                conv_d = 1'b0;
            end else begin
                bcd_d = {bcd_adj[4*NB-2:0], bin_q[VAL_W-1]};
                bin_d = bin_q << 1;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        ref_d = ref_q + 1'b1;
        p_d   = p_q;
        if (ref_q == RW'(REFRESH_CYC - 1)) begin
            ref_d = '0;
            p_d   = (p_q == PW'(N_DIG - 1)) ? '0 : p_q + 1'b1;
        end
    end

    // walk from the MSD down so lz tracks "all digits so far are zero"
    always_comb begin
        lz        = 1'b1;
        sel_dig   = 4'd0;
        sel_blank = 1'b0;
        for (int j = N_DIG - 1; j >= 0; j--) begin
            lz = lz && (dig_q[4*j +: 4] == 4'd0);
            if (PW'(N_DIG - 1 - j) == p_q) begin
                sel_dig   = dig_q[4*j +: 4];
                sel_blank = LZB && lz && (j != 0);
            end
        end
    end

    always_comb begin
        for (int j = 0; j < N_DIG; j++) begin
            anode_d[j] = !((state_q == SHOW) && (PW'(N_DIG - 1 - j) == p_q));
        end
        if ((state_q != SHOW) || conv_q) led_d = 7'h7F;
        else if (ovf_q)                  led_d = 7'b1111110;
        else if (sel_blank)              led_d = 7'h7F;
        else                             led_d = seg_of(sel_dig);
    end

    always_ff @(posedge clock_100Mhz) begin
        if (reset) begin
            bank_q  <= '0;
            idx_q   <= '0;
            dwell_q <= '0;
            ref_q   <= '0;
            p_q     <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            conv_q  <= 1'b0;
            dig_q   <= '0;
            ovf_q   <= 1'b0;
            anode_q <= '1;
            led_q   <= 7'h7F;
        end else begin
            bank_q  <= bank_d;
            idx_q   <= idx_d;
            dwell_q <= dwell_d;
            ref_q   <= ref_d;
            p_q     <= p_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            conv_q  <= conv_d;
            dig_q   <= dig_d;
            ovf_q   <= ovf_d;
            anode_q <= anode_d;
            led_q   <= led_d;
        end
    end

endmodule
